friscv_regfile_sb: RTL and testbench
====================================

// Module: friscv_regfile_sb
// PURPOSE
// - Parametrised ISA register file with a built-in scoreboard. Serves the control unit, ALU and memfy
//   through NB_RD read ports and NB_WR byte-strobed write ports.
// - Each register carries a busy (pending-write) bit. The issuer reserves rd via a lock handshake.
// - A write port releases the lock on writeback. Optional same-cycle write-to-read bypass.
// - Supports RV32I/RV64I (NB_REGS=32) and RV32E (NB_REGS=16).
// PARAMETERS
// - XLEN     32  register width; must be a multiple of 8
// - NB_REGS  32  number of architectural registers; 16 or 32
// - NB_RD    6   number of read ports
// - NB_WR    3   number of write ports; port 0 has highest priority
// - BYPASS   1   1: read ports see the same-cycle write result; 0: read ports see registered state only
// PORTS
// - aclk        in   1             clock, rising edge
// - aresetn     in   1             reset, synchronous, active-low
// - rd_addr     in   NB_RD*5       read port addresses; port p uses [p*5+:5]
// - rd_val      out  NB_RD*XLEN    read values
// - rd_busy     out  NB_RD         addressed register has a pending write
// - lock_valid  in   1             request to reserve a destination register
// - lock_addr   in   5             register to reserve
// - lock_ready  out  1             reservation accepted this cycle
// - wr_en       in   NB_WR         write enable per port
// - wr_addr     in   NB_WR*5       write address per port
// - wr_val      in   NB_WR*XLEN    write data per port
// - wr_strb     in   NB_WR*XLEN/8  byte strobes per port
// - wr_unlock   in   NB_WR         clear the busy bit of wr_addr (only when wr_en=1)
// - busy        out  NB_REGS       scoreboard vector, debug
// - regs_flat   out  NB_REGS*XLEN  all registers, x0 at the LSBs, debug
// BEHAVIOUR
// - Reset (aresetn=0 at a rising edge): all registers = 0 and all busy bits = 0.
//   While reset is held, rd_val = 0, rd_busy = 0 and lock_ready = 1.
// - x0: reads always return 0; x0 is never busy. Writes and locks to x0 are accepted and have no effect.
// - Out-of-range addresses (addr >= NB_REGS):
//   - reads return 0 with rd_busy = 0;
//   - writes are ignored;
//   - locks are accepted with no effect.
// - Write, per port and per byte s: reg[a][8s+:8] <= wr_val[8s+:8] when wr_en=1 and wr_strb[s]=1.
//   The update is visible at the next edge.
// - Several ports writing the same register in one cycle: resolution is per byte; the lowest port index
//   with its strobe set wins that byte.
// - Read, BYPASS=0: rd_val is the registered value; 0-cycle combinational path from rd_addr.
// - Read, BYPASS=1: rd_val is the value the register will hold after this edge
//   (strobe-merged write data). rd_busy is 0 if any write this cycle unlocks that register.
// - Lock handshake: lock_ready = !busy[lock_addr], or lock_addr is x0 or out of range,
//   or some wr_en & wr_unlock port targets lock_addr this cycle.
// - On lock_valid & lock_ready: busy[lock_addr] <= 1 at the edge.
// - lock_valid may be held while lock_ready=0 (WAW stall); lock_addr must stay stable until accepted.
// - Unlock: when wr_en[p] & wr_unlock[p], busy[wr_addr[p]] <= 0, unless the same register is locked
//   this cycle. Lock wins, so the register stays busy for the new producer.
// - A write with wr_unlock=0 updates data only; busy is unchanged (partial or multi-beat loads).
// - Unlock of a register that is not busy: no effect and no error.
// - A write to a busy register by a port with wr_unlock=0 is legal; the data is updated.
// - All outputs are a combinational function of state and inputs. The only state is the regs and busy
//   arrays. No internal FSM; the busy bits form a per-register 2-state machine IDLE <-> PENDING.
// - Reset asserted mid-operation clears busy regardless of same-cycle lock/unlock/write.
// TESTING
// - Reset, then write x5 = 0xDEADBEEF via port 0 with strb = 0xF
//   -> next cycle all read ports at addr 5 = 0xDEADBEEF; x0 reads 0 after a write of 0xFFFFFFFF.
// - Ports 0 and 2 both write x7 (0x11111111, strb=0x3 / 0x22222222, strb=0xF) in one cycle
//   -> x7 = 0x22221111.
// - Lock x9, then lock x9 again
//   -> second lock_ready = 0 until port 1 writes x9 with wr_unlock = 1; that same cycle the lock is accepted
//   and busy[9] stays 1.
// - BYPASS=1, port 1 writes x3 = 0xA5 with strb = 0x1 and unlock while rd_addr = 3, x3 = 0x12345678
//   -> rd_val = 0x123456A5 and rd_busy = 0 in the same cycle.
// - NB_REGS=16: write x20 and lock x20 -> lock_ready = 1, busy unchanged; read x20 = 0.
// - Lock x4, assert aresetn=0 for one cycle while port 0 writes x4 -> after reset busy = 0 and x4 = 0.

Source files
------------

// File: rtl/friscv_regfile_sb_if.sv
// Register file bus: read ports, lock (reservation) handshake, write ports, debug taps.
interface friscv_regfile_sb_if #(
   parameter int XLEN    = 32,
   parameter int NB_REGS = 32,
   parameter int NB_RD   = 6,
   parameter int NB_WR   = 3
);
   logic [NB_RD*5-1:0]      rd_addr;
   logic [NB_RD*XLEN-1:0]   rd_val;
   logic [NB_RD-1:0]        rd_busy;
   logic                    lock_valid;
   logic [4:0]              lock_addr;
   logic                    lock_ready;
   logic [NB_WR-1:0]        wr_en;
   logic [NB_WR*5-1:0]      wr_addr;
   logic [NB_WR*XLEN-1:0]   wr_val;
   logic [NB_WR*XLEN/8-1:0] wr_strb;
   logic [NB_WR-1:0]        wr_unlock;
   logic [NB_REGS-1:0]      busy;
   logic [NB_REGS*XLEN-1:0] regs_flat;

   modport master (
      output rd_addr, lock_valid, lock_addr, wr_en, wr_addr, wr_val, wr_strb, wr_unlock,
      input  rd_val, rd_busy, lock_ready, busy, regs_flat
   );

   modport slave (
      input  rd_addr, lock_valid, lock_addr, wr_en, wr_addr, wr_val, wr_strb, wr_unlock,
      output rd_val, rd_busy, lock_ready, busy, regs_flat
   );
endinterface

// File: rtl/friscv_regfile_sb.sv
// ISA register file with per-register busy scoreboard, byte-strobed multi-port writes,
// lock/unlock reservation handshake and optional same-cycle write-to-read bypass.
module friscv_regfile_sb #(
   parameter int XLEN    = 32,
   parameter int NB_REGS = 32,
   parameter int NB_RD   = 6,
   parameter int NB_WR   = 3,
   parameter int BYPASS  = 1
) (
   input logic                aclk,
   input logic                aresetn,
   friscv_regfile_sb_if.slave bus
);
   localparam int NB_BYTES = XLEN / 8;

   logic [XLEN-1:0]         regs     [NB_REGS];
   logic [XLEN-1:0]         regs_nxt [NB_REGS];
   logic [NB_REGS-1:0]      busy_q;
   logic [NB_REGS-1:0]      busy_nxt;
   logic [NB_REGS-1:0]      unlock_hit;
   logic                    lock_ready;
   logic [NB_RD*XLEN-1:0]   rd_val;
   logic [NB_RD-1:0]        rd_busy;
   logic [NB_REGS*XLEN-1:0] regs_flat;

   // Registers released this cycle by any write port carrying an unlock.
   always_comb begin
      unlock_hit = '0;
      for (int unsigned p = 0; p < NB_WR; p++)
         for (int unsigned r = 1; r < NB_REGS; r++)
            if (bus.wr_en[p] && bus.wr_unlock[p] && bus.wr_addr[p*5+:5] == 5'(r))
               unlock_hit[r] = 1'b1;
   end

   // Next register contents; ports scanned high to low so the lowest port owns each byte.
   always_comb begin
      for (int unsigned r = 0; r < NB_REGS; r++)
         regs_nxt[r] = regs[r];
      for (int unsigned r = 1; r < NB_REGS; r++)
         for (int unsigned q = 0; q < NB_WR; q++)
            for (int unsigned s = 0; s < NB_BYTES; s++)
               if (bus.wr_en[NB_WR-1-q] && bus.wr_addr[(NB_WR-1-q)*5+:5] == 5'(r)
                   && bus.wr_strb[(NB_WR-1-q)*NB_BYTES+s])
                  regs_nxt[r][s*8+:8] = bus.wr_val[(NB_WR-1-q)*XLEN+s*8+:8];
   end

   // Reservation accepted unless the target is busy and not being released this cycle.
   always_comb begin
      lock_ready = 1'b1;
      for (int unsigned r = 1; r < NB_REGS; r++)
         if (bus.lock_addr == 5'(r) && busy_q[r] && !unlock_hit[r])
            lock_ready = 1'b0;
      if (!aresetn)
         lock_ready = 1'b1;
   end

   // Scoreboard update: unlock clears, an accepted lock sets and overrides a same-cycle unlock.
   always_comb begin
      busy_nxt = busy_q & ~unlock_hit;
      for (int unsigned r = 1; r < NB_REGS; r++)
         if (bus.lock_valid && lock_ready && bus.lock_addr == 5'(r))
            busy_nxt[r] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // State: register array and busy bits, synchronous active-low reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         busy_q <= '0;
         for (int unsigned r = 0; r < NB_REGS; r++)
            regs[r] <= '0;
      end else begin
         busy_q <= busy_nxt;
         for (int unsigned r = 0; r < NB_REGS; r++)
            regs[r] <= regs_nxt[r];
      end
   end

   // Read ports; x0 and out-of-range addresses fall through to zero / not busy.
   always_comb begin
      rd_val  = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < NB_RD; p++)
         for (int unsigned r = 1; r < NB_REGS; r++)
            if (aresetn && bus.rd_addr[p*5+:5] == 5'(r)) begin
               rd_val[p*XLEN+:XLEN] = (BYPASS != 0) ? regs_nxt[r] : regs[r];
               rd_busy[p]           = busy_q[r] & ~((BYPASS != 0) & unlock_hit[r]);
            end
   end

   // Debug view of the whole register array, x0 at the LSBs.
   always_comb begin
      regs_flat = '0;
      for (int unsigned r = 0; r < NB_REGS; r++)
         regs_flat[r*XLEN+:XLEN] = regs[r];
   end

   assign bus.rd_val     = rd_val;
   assign bus.rd_busy    = rd_busy;
   assign bus.lock_ready = lock_ready;
   assign bus.busy       = busy_q;
   assign bus.regs_flat  = regs_flat;
endmodule

// File: tb/tb_friscv_regfile_sb.sv
// Bench: two register files (32 regs with bypass, 16 regs without) driven with the same
// stimulus and compared every cycle against an array-based reference model.
module tb_friscv_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NB_RD = 6;
   localparam int NB_WR = 3;
   localparam int NBY   = XLEN / 8;
   localparam int FW    = 32 * XLEN;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   logic [NB_RD*5-1:0]    rd_addr;
   logic                  lock_valid;
   logic [4:0]            lock_addr;
   logic [NB_WR-1:0]      wr_en;
   logic [NB_WR*5-1:0]    wr_addr;
   logic [NB_WR*XLEN-1:0] wr_val;
   logic [NB_WR*NBY-1:0]  wr_strb;
   logic [NB_WR-1:0]      wr_unlock;

   friscv_regfile_sb_if #(.XLEN(XLEN), .NB_REGS(32), .NB_RD(NB_RD), .NB_WR(NB_WR)) bus_a ();
   friscv_regfile_sb_if #(.XLEN(XLEN), .NB_REGS(16), .NB_RD(NB_RD), .NB_WR(NB_WR)) bus_b ();

   friscv_regfile_sb #(.XLEN(XLEN), .NB_REGS(32), .NB_RD(NB_RD), .NB_WR(NB_WR), .BYPASS(1))
      dut_a (.aclk(aclk), .aresetn(aresetn), .bus(bus_a));
   friscv_regfile_sb #(.XLEN(XLEN), .NB_REGS(16), .NB_RD(NB_RD), .NB_WR(NB_WR), .BYPASS(0))
      dut_b (.aclk(aclk), .aresetn(aresetn), .bus(bus_b));

   assign bus_a.rd_addr = rd_addr;     assign bus_b.rd_addr = rd_addr;
   assign bus_a.lock_valid = lock_valid; assign bus_b.lock_valid = lock_valid;
   assign bus_a.lock_addr = lock_addr; assign bus_b.lock_addr = lock_addr;
   assign bus_a.wr_en = wr_en;         assign bus_b.wr_en = wr_en;
   assign bus_a.wr_addr = wr_addr;     assign bus_b.wr_addr = wr_addr;
   assign bus_a.wr_val = wr_val;       assign bus_b.wr_val = wr_val;
   assign bus_a.wr_strb = wr_strb;     assign bus_b.wr_strb = wr_strb;
   assign bus_a.wr_unlock = wr_unlock; assign bus_b.wr_unlock = wr_unlock;

   int n_tests;
   int n_fail;

   // Reference model: [0] = 32 regs with bypass, [1] = 16 regs without.
   logic [XLEN-1:0] mreg  [2][32];
   bit              mbusy [2][32];
   int unsigned     nregs [2] = '{32, 16};
   bit              byp   [2] = '{1'b1, 1'b0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit unlocked(int unsigned a);
      for (int p = 0; p < NB_WR; p++)
         if (wr_en[p] && wr_unlock[p] && wr_addr[p*5+:5] == 5'(a)) return 1'b1;
      return 1'b0;
   endfunction

   // Value register a holds after this edge: per byte, the first port (lowest index) writing it.
   function automatic logic [XLEN-1:0] merged(int c, int unsigned a);
      logic [XLEN-1:0] v;
      v = mreg[c][a];
      for (int s = 0; s < NBY; s++)
         for (int p = 0; p < NB_WR; p++)
            if (wr_en[p] && wr_addr[p*5+:5] == 5'(a) && wr_strb[p*NBY+s]) begin
               v[s*8+:8] = wr_val[p*XLEN+s*8+:8];
               break;
            end
      return v;
   endfunction

   function automatic logic [31:0] busy_vec(int c);
      logic [31:0] v;
      v = '0;
      for (int a = 0; a < 32; a++)
         if (a < int'(nregs[c])) v[a] = mbusy[c][a];
      return v;
   endfunction

   task automatic check_cfg(input int c, input logic [NB_RD*XLEN-1:0] rv, input logic [NB_RD-1:0] rb,
                            input logic lr, input logic [31:0] bz, input logic [FW-1:0] rf);
      int unsigned a;
      logic [XLEN-1:0] ev;
      bit eb, elr;
      for (int p = 0; p < NB_RD; p++) begin
         a  = 32'(rd_addr[p*5+:5]);
         ev = '0;
         eb = 1'b0;
         if (aresetn && a != 0 && a < nregs[c]) begin
            ev = byp[c] ? merged(c, a) : mreg[c][a];
            eb = mbusy[c][a] && !(byp[c] && unlocked(a));
         end
         check($sformatf("cfg%0d rd_val[%0d]", c, p), rv[p*XLEN+:XLEN], ev);
         check($sformatf("cfg%0d rd_busy[%0d]", c, p), 32'(rb[p]), 32'(eb));
      end
      a   = 32'(lock_addr);
      elr = !aresetn || a == 0 || a >= nregs[c] || !mbusy[c][a] || unlocked(a);
      check($sformatf("cfg%0d lock_ready", c), 32'(lr), 32'(elr));
      check($sformatf("cfg%0d busy", c), bz, busy_vec(c));
      for (int r = 0; r < int'(nregs[c]); r++)
         check($sformatf("cfg%0d reg[%0d]", c, r), rf[r*XLEN+:XLEN], mreg[c][r]);
   endtask

   task automatic model_edge(input int c);
      logic [XLEN-1:0] nr [32];
      bit nb [32];
      for (int a = 0; a < 32; a++) begin
         nr[a] = mreg[c][a];
         nb[a] = mbusy[c][a];
      end
      if (!aresetn) begin
         for (int a = 0; a < 32; a++) begin
            nr[a] = '0;
            nb[a] = 1'b0;
         end
      end else begin
         for (int a = 1; a < int'(nregs[c]); a++) begin
            nr[a] = merged(c, a);
            if (unlocked(a)) nb[a] = 1'b0;
            if (lock_valid && lock_addr == 5'(a)) nb[a] = 1'b1;
         end
      end
      for (int a = 0; a < 32; a++) begin
         mreg[c][a]  = nr[a];
         mbusy[c][a] = nb[a];
      end
   endtask

   task automatic step();
      @(negedge aclk);
      check_cfg(0, bus_a.rd_val, bus_a.rd_busy, bus_a.lock_ready, 32'(bus_a.busy), FW'(bus_a.regs_flat));
      check_cfg(1, bus_b.rd_val, bus_b.rd_busy, bus_b.lock_ready, 32'(bus_b.busy), FW'(bus_b.regs_flat));
      @(posedge aclk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic idle();
      rd_addr = '0; lock_valid = 1'b0; lock_addr = '0;
      wr_en = '0; wr_addr = '0; wr_val = '0; wr_strb = '0; wr_unlock = '0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 32; a++) begin
            mreg[c][a]  = '0;
            mbusy[c][a] = 1'b0;
         end
      idle();
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;

      // reset held: outputs forced quiet
      lock_valid = 1'b1; lock_addr = 5'd9; rd_addr = {NB_RD{5'd5}};
      #1;
      check("rst_lock_ready", 32'(bus_a.lock_ready), 32'd1);
      check("rst_rd_val", bus_a.rd_val[31:0], 32'd0);
      step();

      // x5 write then read on all ports
      aresetn = 1'b1; idle();
      wr_en[0] = 1'b1; wr_addr[0+:5] = 5'd5; wr_val[0+:32] = 32'hDEADBEEF; wr_strb[0+:4] = 4'hF;
      step();
      idle(); rd_addr = {NB_RD{5'd5}};
      #1;
      for (int p = 0; p < NB_RD; p++)
         check($sformatf("x5_read[%0d]", p), bus_a.rd_val[p*XLEN+:XLEN], 32'hDEADBEEF);
      step();
      idle(); wr_en[0] = 1'b1; wr_addr[0+:5] = 5'd0; wr_val[0+:32] = 32'hFFFFFFFF; wr_strb[0+:4] = 4'hF;
      step();
      idle();
      #1;
      check("x0_read_a", bus_a.rd_val[31:0], 32'd0);
      check("x0_read_b", bus_b.rd_val[31:0], 32'd0);
      step();

      // two ports on x7, lowest port wins per byte
      idle(); wr_en = 3'b101;
      wr_addr[0+:5] = 5'd7;  wr_val[0+:32]  = 32'h11111111; wr_strb[0+:4] = 4'h3;
      wr_addr[10+:5] = 5'd7; wr_val[64+:32] = 32'h22222222; wr_strb[8+:4] = 4'hF;
      step();
      check("x7_merge", bus_a.regs_flat[7*XLEN+:XLEN], 32'h22221111);

      // WAW stall on x9, released by an unlocking write the same cycle
      idle(); lock_valid = 1'b1; lock_addr = 5'd9;
      #1;
      check("lock9_first", 32'(bus_a.lock_ready), 32'd1);
      step();
      check("lock9_stall", 32'(bus_a.lock_ready), 32'd0);
      step();
      wr_en[1] = 1'b1; wr_addr[5+:5] = 5'd9; wr_val[32+:32] = 32'h99; wr_strb[4+:4] = 4'hF; wr_unlock[1] = 1'b1;
      #1;
      check("lock9_unlock_ready", 32'(bus_a.lock_ready), 32'd1);
      step();
      check("lock9_busy_kept", 32'(bus_a.busy[9]), 32'd1);

      // bypass of a strobed, unlocking write
      idle(); wr_en[0] = 1'b1; wr_addr[0+:5] = 5'd3; wr_val[0+:32] = 32'h12345678; wr_strb[0+:4] = 4'hF;
      lock_valid = 1'b1; lock_addr = 5'd3;
      step();
      idle(); wr_en[1] = 1'b1; wr_addr[5+:5] = 5'd3; wr_val[32+:32] = 32'hA5; wr_strb[4+:4] = 4'h1;
      wr_unlock[1] = 1'b1; rd_addr[0+:5] = 5'd3;
      #1;
      check("byp_val", bus_a.rd_val[31:0], 32'h123456A5);
      check("byp_busy", 32'(bus_a.rd_busy[0]), 32'd0);
      check("nobyp_val", bus_b.rd_val[31:0], 32'h12345678);
      check("nobyp_busy", 32'(bus_b.rd_busy[0]), 32'd1);
      step();

      // out-of-range x20 on the 16-register file
      idle(); wr_en[0] = 1'b1; wr_addr[0+:5] = 5'd20; wr_val[0+:32] = 32'hCAFEF00D; wr_strb[0+:4] = 4'hF;
      lock_valid = 1'b1; lock_addr = 5'd20; rd_addr[0+:5] = 5'd20;
      #1;
      check("oor_lock_ready", 32'(bus_b.lock_ready), 32'd1);
      check("oor_read", bus_b.rd_val[31:0], 32'd0);
      check("oor_rd_busy", 32'(bus_b.rd_busy[0]), 32'd0);
      step();
      check("oor_busy", 32'(bus_b.busy), 32'h0000_0200);

      // reset mid-operation beats a same-cycle write
      idle(); lock_valid = 1'b1; lock_addr = 5'd4;
      step();
      idle(); aresetn = 1'b0;
      wr_en[0] = 1'b1; wr_addr[0+:5] = 5'd4; wr_val[0+:32] = 32'hFFFFFFFF; wr_strb[0+:4] = 4'hF;
      step();
      aresetn = 1'b1; idle();
      #1;
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_x4", bus_a.regs_flat[4*XLEN+:XLEN], 32'd0);
      step();

      // random traffic, addresses biased to collide
      for (int i = 0; i < 600; i++) begin
         aresetn = ($urandom_range(40) != 0);
         for (int p = 0; p < NB_RD; p++)
            rd_addr[p*5+:5] = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(11));
         lock_valid = 1'($urandom_range(1));
         lock_addr  = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(11));
         for (int p = 0; p < NB_WR; p++) begin
            wr_en[p]     = 1'($urandom_range(1));
            wr_addr[p*5+:5] = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(11));
            wr_val[p*XLEN+:XLEN] = $urandom;
            wr_strb[p*NBY+:NBY]  = 4'($urandom);
            wr_unlock[p] = 1'($urandom_range(1));
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
